// File: rtl/delay_pkg.sv
// Shared types and defaults for the multi-channel delay timer.
//   mode_e  : per-channel run mode (periodic / one-shot)
//   state_e : per-channel FSM state (idle / running)
//   DEF_*   : default counter width and reset period
package delay_pkg;

    localparam int unsigned DEF_CBITS     = 17;
    localparam int unsigned DEF_N_DEFAULT = 100000;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/delay_chan.sv
// One timer channel: counts 0..P and pulses sig_o for one cycle on expiry.
// A shadow period holds writes made while running; it is promoted to the
// active period on expiry or restart.
// Optional feature macro: DELAY_ERR_CHECK_EN (builds the sticky err_o flag).
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wr_i                 write period_i/mode_i into this channel
//   period_i, mode_i     new period and mode (1 = one-shot)
//   start_i, stop_i      start/restart, stop (stop wins)
//   err_clr_i            clear sticky err_o
//   sig_o                one-cycle expiry pulse
//   busy_o               channel running
//   flg_o                running and count within active period
//   err_o                sticky count-beyond-period flag
module delay_chan
    import delay_pkg::*;
#(
    parameter int unsigned CBITS     = DEF_CBITS,
    parameter int unsigned N_DEFAULT = DEF_N_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [CBITS-1:0] period_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             err_clr_i,
    output logic             sig_o,
    output logic             busy_o,
    output logic             flg_o,
    output logic             err_o
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] act_q, act_d;
    logic [CBITS-1:0] shd_q, shd_d;
    logic             sig_q, sig_d;
    logic             flg_q, flg_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        shd_d   = shd_q;
        sig_d   = 1'b0;

        if (wr_i) begin
            shd_d  = period_i;
            mode_d = mode_e'(mode_i);
            // An idle channel has nothing in flight, so the write is live at once.
            if (state_q == ST_IDLE) begin
                act_d = period_i;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (start_i) begin
                    cnt_d = '0;
                    act_d = shd_d;
                end else if (cnt_q == act_q) begin
                    cnt_d = '0;
                    sig_d = 1'b1;
                    act_d = shd_d;
                    // Mode is not shadowed: a one-shot write mid-run ends this expiry.
                    if (mode_d == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        flg_d = (state_d == ST_RUN) && (cnt_d <= act_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_PERIODIC;
            cnt_q   <= '0;
            act_q   <= CBITS'(N_DEFAULT);
            shd_q   <= CBITS'(N_DEFAULT);
            sig_q   <= 1'b0;
            flg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            sig_q   <= sig_d;
            flg_q   <= flg_d;
        end
    end

    assign sig_o  = sig_q;
    assign busy_o = (state_q == ST_RUN);
    assign flg_o  = flg_q;

`ifdef DELAY_ERR_CHECK_EN
    logic err_q;

    // Set has priority over clear so a persisting violation is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (cnt_q > act_q) || (err_q && !err_clr_i);
        end
    end

    assign err_o = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
`endif

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay/period timer: NCH independent delay_chan
// instances sharing one configuration write port.
// Optional feature macro: DELAY_ERR_CHECK_EN (builds err_o and cfg_err_o).
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cfg_we_i, cfg_ch_i             configuration write strobe and target channel
//   cfg_period_i, cfg_mode_i       period and mode (1 = one-shot) to write
//   start_i, stop_i                per-channel start/restart and stop
//   err_clr_i                      clears all sticky error bits
//   sig_o, busy_o, flg_o, err_o    per-channel status
//   cfg_err_o                      sticky: write aimed at a nonexistent channel
module delay_timer_mc
    import delay_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CBITS     = DEF_CBITS,
    parameter int unsigned N_DEFAULT = DEF_N_DEFAULT,
    parameter int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CBITS-1:0] cfg_period_i,
    input  logic             cfg_mode_i,
    input  logic [NCH-1:0]   start_i,
    input  logic [NCH-1:0]   stop_i,
    input  logic             err_clr_i,
    output logic [NCH-1:0]   sig_o,
    output logic [NCH-1:0]   busy_o,
    output logic [NCH-1:0]   flg_o,
    output logic [NCH-1:0]   err_o,
    output logic             cfg_err_o
);

    logic [NCH-1:0] wr;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Out-of-range channel numbers match no instance and so write nothing.
        assign wr[i] = cfg_we_i && (32'(cfg_ch_i) == 32'(i));

        delay_chan #(
            .CBITS     (CBITS),
            .N_DEFAULT (N_DEFAULT)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .wr_i      (wr[i]),
            .period_i  (cfg_period_i),
            .mode_i    (cfg_mode_i),
            .start_i   (start_i[i]),
            .stop_i    (stop_i[i]),
            .err_clr_i (err_clr_i),
            .sig_o     (sig_o[i]),
            .busy_o    (busy_o[i]),
            .flg_o     (flg_o[i]),
            .err_o     (err_o[i])
        );
    end

`ifdef DELAY_ERR_CHECK_EN
    logic cfg_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (cfg_we_i && (32'(cfg_ch_i) >= 32'(NCH))) || (cfg_err_q && !err_clr_i);
        end
    end

    assign cfg_err_o = cfg_err_q;
`else
    assign cfg_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_delay_timer_mc.sv
// Self-checking bench for delay_timer_mc: directed scenarios plus random
// traffic, all compared against an event-scheduling reference model that
// tracks the absolute cycle of each channel's next expiry.
module tb_delay_timer_mc;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CBITS = 17;
    localparam int unsigned NDEF  = 100000;
    localparam int unsigned CHW   = 3;
    localparam int unsigned VW    = 4 * NCH + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CHW-1:0]   cfg_ch = '0;
    logic [CBITS-1:0] cfg_period = '0;
    logic             cfg_mode = 1'b0;
    logic [NCH-1:0]   start = '0;
    logic [NCH-1:0]   stop = '0;
    logic             err_clr = 1'b0;
    logic [NCH-1:0]   sig, busy, flg, err;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;

    delay_timer_mc #(
        .NCH       (NCH),
        .CBITS     (CBITS),
        .N_DEFAULT (NDEF),
        .CH_W      (CHW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_we_i     (cfg_we),
        .cfg_ch_i     (cfg_ch),
        .cfg_period_i (cfg_period),
        .cfg_mode_i   (cfg_mode),
        .start_i      (start),
        .stop_i       (stop),
        .err_clr_i    (err_clr),
        .sig_o        (sig),
        .busy_o       (busy),
        .flg_o        (flg),
        .err_o        (err),
        .cfg_err_o    (cfg_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint         t;
    bit             m_run  [NCH];
    longint         m_next [NCH];
    int unsigned    m_act  [NCH];
    int unsigned    m_shd  [NCH];
    bit             m_mode [NCH];
    logic [NCH-1:0] m_sig;
    bit             m_cfg_err;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i]  = 1'b0;
            m_next[i] = 0;
            m_act[i]  = NDEF;
            m_shd[i]  = NDEF;
            m_mode[i] = 1'b0;
        end
        m_sig     = '0;
        m_cfg_err = 1'b0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit wr;
            wr       = cfg_we && (int'(cfg_ch) == i);
            m_sig[i] = 1'b0;
            if (wr) begin
                m_shd[i]  = cfg_period;
                m_mode[i] = cfg_mode;
                if (!m_run[i]) m_act[i] = cfg_period;
            end
            if (m_run[i]) begin
                if (stop[i]) begin
                    m_run[i] = 1'b0;
                end else if (start[i]) begin
                    m_act[i]  = m_shd[i];
                    m_next[i] = t + longint'(m_act[i]) + 1;
                end else if (t == m_next[i]) begin
                    m_sig[i] = 1'b1;
                    m_act[i] = m_shd[i];
                    if (m_mode[i]) m_run[i] = 1'b0;
                    else m_next[i] = t + longint'(m_act[i]) + 1;
                end
            end else if (start[i] && !stop[i]) begin
                m_run[i]  = 1'b1;
                m_next[i] = t + longint'(m_act[i]) + 1;
            end
        end
`ifdef DELAY_ERR_CHECK_EN
        m_cfg_err = (cfg_we && int'(cfg_ch) >= NCH) || (m_cfg_err && !err_clr);
`endif
        t++;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = m_run[i];
        return {m_cfg_err, {NCH{1'b0}}, b, b, m_sig};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cfg_write(input int ch, input int unsigned p, input bit m);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_period = CBITS'(p); cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic stop_all();
        stop = '1;
        tick();
        stop = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cfg_err, err, flg, busy, sig} !== '0) begin
            errors++;
            $display("FAIL reset_hold got %h want 0", {cfg_err, err, flg, busy, sig});
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got %h want %h", {cfg_err, err, flg, busy, sig}, exp_vec());
        end
    endtask

    task automatic test_periodic();
        int pulses[$];
        cfg_write(0, 3, 1'b0);
        start = 4'b0001;
        tick();
        start = '0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            checks++;
            if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL periodic_e%0d got %h want %h", e, {cfg_err, err, flg, busy, sig},
                         exp_vec());
            end
            if (sig[0]) pulses.push_back(e);
        end
        checks++;
        if (pulses.size() != 3 || pulses[0] != 4 || pulses[1] != 8 || pulses[2] != 12) begin
            errors++;
            $display("FAIL periodic_edges got %p want '{4,8,12}", pulses);
        end
        stop_all();
    endtask

    task automatic test_oneshot();
        int n = 0;
        cfg_write(1, 2, 1'b1);
        start = 4'b0010;
        tick();
        start = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL oneshot_e%0d got %h want %h", e, {cfg_err, err, flg, busy, sig},
                         exp_vec());
            end
            if (sig[1]) n++;
            if (e == 3) begin
                checks++;
                if ({sig[1], busy[1]} !== 2'b10) begin
                    errors++;
                    $display("FAIL oneshot_end got sig=%b busy=%b want sig=1 busy=0", sig[1],
                             busy[1]);
                end
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL oneshot_count got %0d want 1", n);
        end
    endtask

    task automatic test_period_change();
        int pulses[$];
        cfg_write(0, 3, 1'b0);
        start = 4'b0001;
        tick();
        start = '0;
        for (int e = 1; e <= 10; e++) begin
            if (e == 2) begin
                cfg_we = 1'b1; cfg_ch = 3'd0; cfg_period = CBITS'(1); cfg_mode = 1'b0;
            end
            tick();
            cfg_we = 1'b0;
            checks++;
            if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL pchange_e%0d got %h want %h", e, {cfg_err, err, flg, busy, sig},
                         exp_vec());
            end
            if (sig[0]) pulses.push_back(e);
        end
        checks++;
        if (pulses.size() != 4 || pulses[0] != 4 || pulses[1] != 6 || pulses[3] != 10) begin
            errors++;
            $display("FAIL pchange_edges got %p want '{4,6,8,10}", pulses);
        end
        stop_all();
    endtask

    task automatic test_start_stop();
        cfg_write(2, 5, 1'b0);
        start = 4'b0100;
        tick();
        start = '0;
        repeat (3) tick();
        start = 4'b0100;
        stop  = 4'b0100;
        tick();
        start = '0;
        stop  = '0;
        checks++;
        if ({busy[2], sig[2]} !== 2'b00 || {cfg_err, err, flg, busy, sig} !== exp_vec()) begin
            errors++;
            $display("FAIL start_stop got %h want %h", {cfg_err, err, flg, busy, sig}, exp_vec());
        end
        cfg_write(2, 0, 1'b0);
        start = 4'b0100;
        tick();
        start = '0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (sig[2] !== 1'b1 || {cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL p0_e%0d got %h want %h", e, {cfg_err, err, flg, busy, sig},
                         exp_vec());
            end
        end
        stop_all();
    endtask

    task automatic test_cfg_err();
        cfg_write(4, 1, 1'b1);
        checks++;
        if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
            errors++;
            $display("FAIL cfg_err_set got %h want %h", {cfg_err, err, flg, busy, sig}, exp_vec());
        end
        // Periods must be untouched: run every channel and compare pulse timing.
        start = '1;
        tick();
        start = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL cfg_err_run_e%0d got %h want %h", e,
                         {cfg_err, err, flg, busy, sig}, exp_vec());
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clr got %b want 0", cfg_err);
        end
        stop_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            cfg_we     = ($urandom % 6) == 0;
            cfg_ch     = CHW'($urandom_range(0, 4));
            cfg_period = CBITS'($urandom_range(0, 6));
            cfg_mode   = ($urandom % 3) == 0;
            for (int i = 0; i < NCH; i++) begin
                start[i] = ($urandom % 9) == 0;
                stop[i]  = ($urandom % 17) == 0;
            end
            err_clr = ($urandom % 16) == 0;
            tick();
            checks++;
            if ({cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL random_c%0d got %h want %h", c, {cfg_err, err, flg, busy, sig},
                         exp_vec());
            end
        end
        cfg_we = 1'b0; start = '0; stop = '0; err_clr = 1'b0;
        stop_all();
    endtask

    task automatic test_reset_mid_run();
        cfg_write(3, 2, 1'b0);
        start = 4'b1000;
        tick();
        start = '0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_err, err, flg, busy, sig} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", {cfg_err, err, flg, busy, sig});
        end
        model_reset();
        #1 rst_n = 1'b1;
        start = 4'b1000;
        tick();
        start = '0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            checks++;
            if (sig[3] !== 1'b0 || busy[3] !== 1'b1 ||
                {cfg_err, err, flg, busy, sig} !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset_e%0d got %h want %h", e,
                         {cfg_err, err, flg, busy, sig}, exp_vec());
            end
        end
        stop_all();
    endtask

    initial begin
        t = 0;
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_period_change();
        test_start_stop();
        test_cfg_err();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
